logic_op_arbiter: RTL and testbench

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

---
 rtl/logic_op_arbiter_pkg.sv | 20 ++
 rtl/logic_op_arbiter_logic_unit.sv | 29 ++
 rtl/logic_op_arbiter.sv | 95 +++++++++
 tb/tb_logic_op_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the two-requester bitwise logic-op arbiter:
// opcode constants and the result-register FSM encoding.
package logic_op_arbiter_pkg;

    localparam logic [2:0] OP_BUF  = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    // IDLE: result register empty, BUSY: result register full
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/logic_op_arbiter_logic_unit.sv
// Purely combinational bitwise operator; b is ignored for BUF and NOT.
module logic_unit
    import logic_op_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
        result = a;
        case (op)
            OP_BUF:  result = a;
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            default: result = a;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter between two requesters feeding one shared logic unit,
// with a single registered result slot that supports one result per cycle.
module logic_op_arbiter
    import logic_op_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready,

    output logic [15:0]      done_count
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant_id;
    logic             accept_window;
    logic             accept;
    logic             rsp_fire;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] lu_result;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign grant_id      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept_window = (state == IDLE) || rsp_ready;
    assign accept        = !rst && accept_window && (req0_valid || req1_valid);

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    assign rsp_valid = (state == BUSY);
    assign rsp_fire  = rsp_valid && rsp_ready;

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (lu_result)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (rsp_ready) state_next = accept ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            done_count <= 16'h0000;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= grant_id;
                rsp_id     <= grant_id;
                rsp_data   <= lu_result;
            end
            if (rsp_fire) begin
                done_count <= done_count + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter with hand-computed expectations.
module tb_logic_op_arbiter;
    import logic_op_arbiter_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_id, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [15:0]      done_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] op_exp [8];

    logic_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        op_exp[0] = 8'hCA; op_exp[1] = 8'h35; op_exp[2] = 8'h80; op_exp[3] = 8'h7F;
        op_exp[4] = 8'hEF; op_exp[5] = 8'h10; op_exp[6] = 8'h6F; op_exp[7] = 8'h90;

        // Reset with both requesters valid: no ready may show.
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b1; req1_op = OP_AND; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_done_count", 32'(done_count), 32'h0);
        check("rst_req0_ready", 32'(req0_ready), 32'h0);
        check("rst_req1_ready", 32'(req1_ready), 32'h0);
        tick(); tick();
        req1_valid = 1'b0; req0_valid = 1'b0;
        rst = 1'b0;

        // Single AND on req0: F0 & 3C = 30.
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hF0; req0_b = 8'h3C; rsp_ready = 1'b1;
        #1;
        check("and_req0_ready", 32'(req0_ready), 32'h1);
        check("and_req1_ready", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("and_rsp_valid", 32'(rsp_valid), 32'h1);
        check("and_rsp_id", 32'(rsp_id), 32'h0);
        check("and_rsp_data", 32'(rsp_data), 32'h30);
        tick();
        check("and_done_count", 32'(done_count), 32'h1);
        check("and_back_idle", 32'(rsp_valid), 32'h0);

        // All eight opcodes through req1.
        for (int i = 0; i < 8; i++) begin
            req1_valid = 1'b1; req1_op = 3'(i); req1_a = 8'hCA; req1_b = 8'hA5;
            #1;
            check("op_req1_ready", 32'(req1_ready), 32'h1);
            tick();
            req1_valid = 1'b0;
            #1;
            check($sformatf("op%0d_rsp_id", i), 32'(rsp_id), 32'h1);
            check($sformatf("op%0d_rsp_data", i), 32'(rsp_data), 32'(op_exp[i]));
            tick();
        end
        check("ops_done_count", 32'(done_count), 32'd9);

        // Continuous contention: grants alternate 0,1,0,1, one result per cycle.
        req0_valid = 1'b1; req0_op = OP_BUF; req0_a = 8'h11; req0_b = 8'hFF;
        req1_valid = 1'b1; req1_op = OP_BUF; req1_a = 8'h22; req1_b = 8'hFF;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                check($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
                check($sformatf("rr%0d_rsp_id", i), 32'(rsp_id), 32'((i - 1) % 2));
                check($sformatf("rr%0d_rsp_data", i), 32'(rsp_data), ((i - 1) % 2 == 1) ? 32'h22 : 32'h11);
            end
            check($sformatf("rr%0d_req0_ready", i), 32'(req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("rr%0d_req1_ready", i), 32'(req1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
            tick();
        end
        check("rr_last_rsp_id", 32'(rsp_id), 32'h1);
        check("rr_last_rsp_data", 32'(rsp_data), 32'h22);

        // Backpressure: held result stable, both readies low for five cycles.
        rsp_ready = 1'b0; req1_valid = 1'b0; req0_a = 8'h33;
        #1;
        check("bp_req0_ready", 32'(req0_ready), 32'h0);
        check("bp_done_count", 32'(done_count), 32'd12);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
            check($sformatf("bp%0d_rsp_id", i), 32'(rsp_id), 32'h1);
            check($sformatf("bp%0d_rsp_data", i), 32'(rsp_data), 32'h22);
            check($sformatf("bp%0d_req0_ready", i), 32'(req0_ready), 32'h0);
            check($sformatf("bp%0d_req1_ready", i), 32'(req1_ready), 32'h0);
        end
        check("bp_done_held", 32'(done_count), 32'd12);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_req0_ready", 32'(req0_ready), 32'h1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("bp_next_rsp_id", 32'(rsp_id), 32'h0);
        check("bp_next_rsp_data", 32'(rsp_data), 32'h33);
        check("bp_next_done", 32'(done_count), 32'd13);
        tick();
        check("bp_drain_idle", 32'(rsp_valid), 32'h0);
        check("bp_drain_done", 32'(done_count), 32'd14);

        // Drive done_count to FFFF with back-to-back handshakes, then wrap.
        req0_valid = 1'b1; req0_op = OP_NOT; req0_a = 8'h0F; rsp_ready = 1'b1;
        tick();
        repeat (65535 - 14) tick();
        check("wrap_at_ffff", 32'(done_count), 32'hFFFF);
        check("wrap_rsp_data", 32'(rsp_data), 32'hF0);
        tick();
        check("wrap_to_zero", 32'(done_count), 32'h0000);
        req0_valid = 1'b0;
        tick();
        check("wrap_drain_done", 32'(done_count), 32'h0001);
        check("wrap_drain_idle", 32'(rsp_valid), 32'h0);

        // Reset while holding a result: it is discarded and req0 wins next contention.
        req0_valid = 1'b1; req0_op = OP_BUF; req0_a = 8'h55; rsp_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        check("pre_rst_rsp_data", 32'(rsp_data), 32'h55);
        #2;
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h66;
        req1_valid = 1'b1; req1_op = OP_BUF; req1_a = 8'h77;
        rsp_ready = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'h0);
        check("mid_rst_done", 32'(done_count), 32'h0);
        check("mid_rst_req0_ready", 32'(req0_ready), 32'h0);
        check("mid_rst_req1_ready", 32'(req1_ready), 32'h0);
        tick();
        check("in_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_req0_ready", 32'(req0_ready), 32'h1);
        check("post_rst_req1_ready", 32'(req1_ready), 32'h0);
        tick();
        check("post_rst_rsp_id", 32'(rsp_id), 32'h0);
        check("post_rst_rsp_data", 32'(rsp_data), 32'h66);
        check("post_rst_done", 32'(done_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
